fifo_lvl: RTL and testbench

Parametrised synchronous FIFO that succeeds the basic B/W FIFO used for inter-unit buffering. It adds:
- an occupancy count, programmable almost-full/almost-empty thresholds and a high-water mark;
- sticky overflow/underflow error flags and a synchronous flush;
- correct behaviour for simultaneous read/write at the full and empty boundaries.

It sits between producer/consumer units in the same clock domain, with first-word-fall-through read data.

---
 rtl/fifo_lvl_pkg.sv | 24 ++
 rtl/fifo_lvl_mem.sv | 23 ++
 rtl/fifo_lvl.sv | 93 +++++++++
 tb/tb_fifo_lvl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_lvl_pkg.sv
// Shared level-flag type and decoder for the fifo_lvl FIFO.
// One decoder serves both the reset values and the next-state flags, so they cannot disagree.
package fifo_lvl_pkg;

   typedef struct packed {
      logic empty;
      logic full;
      logic almost_empty;
      logic almost_full;
   } lvl_flags_t;

   function automatic lvl_flags_t lvl_decode(input int unsigned cnt,
                                             input int unsigned depth,
                                             input int unsigned af_lvl,
                                             input int unsigned ae_lvl);
      lvl_flags_t f;
      f.empty        = (cnt == 0);
      f.full         = (cnt == depth);
      f.almost_empty = (cnt <= ae_lvl);
      f.almost_full  = (cnt >= af_lvl);
      return f;
   endfunction

endpackage

// File: rtl/fifo_lvl_mem.sv
// D x B register file: one synchronous write port and one asynchronous read port.
// Storage has no reset; the controller's pointers decide which words are valid.
module fifo_lvl_mem #(
   parameter int B = 8,
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         we_i,
   input  logic [W-1:0] waddr_i,
   input  logic [B-1:0] wdata_i,
   input  logic [W-1:0] raddr_i,
   output logic [B-1:0] rdata_o
);

   logic [B-1:0] mem_q [2**W];

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_lvl.sv
// Synchronous first-word-fall-through FIFO with occupancy count, level flags,
// high-water mark, sticky overflow/underflow and synchronous flush.
module fifo_lvl
   import fifo_lvl_pkg::*;
#(
   parameter int B      = 8,
   parameter int W      = 4,
   parameter int AF_LVL = 2**W - 2,
   parameter int AE_LVL = 1
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         flush,
   input  logic         wr,
   input  logic [B-1:0] w_data,
   input  logic         rd,
   output logic [B-1:0] r_data,
   output logic         empty,
   output logic         full,
   output logic         almost_empty,
   output logic         almost_full,
   output logic [W:0]   count,
   output logic [W:0]   hwm,
   output logic         overflow,
   output logic         underflow
);

   localparam int D = 2**W;
   localparam lvl_flags_t RST_FLAGS = lvl_decode(0, D, AF_LVL, AE_LVL);

   logic [W-1:0] w_ptr_q, r_ptr_q;
   logic [W:0]   count_q, count_d;
   logic [W:0]   hwm_q, hwm_d;
   lvl_flags_t   flags_q, flags_d;
   logic         ovf_q, udf_q;
   logic         acc_wr, acc_rd;

   // When full, a simultaneous read frees the slot, so the write still goes in.
   always_comb begin
      acc_rd  = rd & ~flags_q.empty;
      acc_wr  = wr & (~flags_q.full | rd);
      count_d = count_q + (W+1)'(acc_wr) - (W+1)'(acc_rd);
      hwm_d   = (count_d > hwm_q) ? count_d : hwm_q;
      flags_d = lvl_decode(32'(count_d), D, AF_LVL, AE_LVL);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         w_ptr_q <= '0;
         r_ptr_q <= '0;
         count_q <= '0;
         hwm_q   <= '0;
         flags_q <= RST_FLAGS;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else if (flush) begin
         w_ptr_q <= '0;
         r_ptr_q <= '0;
         count_q <= '0;
         hwm_q   <= '0;
         flags_q <= RST_FLAGS;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else begin
         if (acc_wr) w_ptr_q <= w_ptr_q + W'(1);
         if (acc_rd) r_ptr_q <= r_ptr_q + W'(1);
         count_q <= count_d;
         hwm_q   <= hwm_d;
         flags_q <= flags_d;
         if (wr & ~acc_wr) ovf_q <= 1'b1;
         if (rd & ~acc_rd) udf_q <= 1'b1;
      end
   end

   fifo_lvl_mem #(.B(B), .W(W)) u_mem (
      .clk     (clk),
      .we_i    (acc_wr & ~flush),
      .waddr_i (w_ptr_q),
      .wdata_i (w_data),
      .raddr_i (r_ptr_q),
      .rdata_o (r_data)
   );

   assign empty        = flags_q.empty;
   assign full         = flags_q.full;
   assign almost_empty = flags_q.almost_empty;
   assign almost_full  = flags_q.almost_full;
   assign count        = count_q;
   assign hwm          = hwm_q;
   assign overflow     = ovf_q;
   assign underflow    = udf_q;

endmodule

// File: tb/tb_fifo_lvl.sv
// Self-checking bench for fifo_lvl (B=8, W=2, AF_LVL=3, AE_LVL=1):
// directed vector table, randomized run against a queue model, and async reset.
module tb_fifo_lvl;

   logic       clk = 1'b0;
   logic       reset_n, flush, wr, rd;
   logic [7:0] w_data, r_data;
   logic       empty, full, almost_empty, almost_full, overflow, underflow;
   logic [2:0] count, hwm;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   fifo_lvl #(.B(8), .W(2), .AF_LVL(3), .AE_LVL(1)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .flush        (flush),
      .wr           (wr),
      .w_data       (w_data),
      .rd           (rd),
      .r_data       (r_data),
      .empty        (empty),
      .full         (full),
      .almost_empty (almost_empty),
      .almost_full  (almost_full),
      .count        (count),
      .hwm          (hwm),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   typedef struct {
      logic       fl;
      logic       w;
      logic       r;
      logic [7:0] wd;
      logic [2:0] cnt;
      logic [2:0] hw;
      logic [5:0] flg;   // {empty, full, almost_empty, almost_full, overflow, underflow}
      logic       chk;
      logic [7:0] rdv;
   } vec_t;

   vec_t vecs [24];

   function automatic logic [5:0] flags_now();
      return {empty, full, almost_empty, almost_full, overflow, underflow};
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input logic f, input logic w, input logic r, input logic [7:0] d);
      flush = f; wr = w; rd = r; w_data = d;
      @(posedge clk);
      #1;
      flush = 1'b0; wr = 1'b0; rd = 1'b0;
   endtask

   // Reference model: a queue of stored words plus sticky bits and the high-water mark.
   logic [7:0] mq[$];
   int         m_hwm;
   logic       m_ovf, m_udf;

   task automatic model_step(input logic f, input logic w, input logic r, input logic [7:0] d);
      bit racc, wacc;
      if (f) begin
         mq.delete(); m_hwm = 0; m_ovf = 0; m_udf = 0;
      end else begin
         racc = r && (mq.size() != 0);
         wacc = w && ((mq.size() != 4) || r);
         if (r && !racc) m_udf = 1;
         if (w && !wacc) m_ovf = 1;
         if (racc) void'(mq.pop_front());
         if (wacc) mq.push_back(d);
         if (mq.size() > m_hwm) m_hwm = mq.size();
      end
   endtask

   initial begin
      logic [5:0] exp_flg;
      logic f, w, r;
      logic [7:0] d;
      int n;

      vecs[0]  = '{1'b0,1'b1,1'b0,8'h11, 3'd1,3'd1,6'b001000,1'b1,8'h11};
      vecs[1]  = '{1'b0,1'b1,1'b0,8'h22, 3'd2,3'd2,6'b000000,1'b1,8'h11};
      vecs[2]  = '{1'b0,1'b1,1'b0,8'h33, 3'd3,3'd3,6'b000100,1'b1,8'h11};
      vecs[3]  = '{1'b0,1'b1,1'b0,8'h44, 3'd4,3'd4,6'b010100,1'b1,8'h11};
      vecs[4]  = '{1'b0,1'b1,1'b0,8'h55, 3'd4,3'd4,6'b010110,1'b1,8'h11};
      vecs[5]  = '{1'b0,1'b0,1'b1,8'h00, 3'd3,3'd4,6'b000110,1'b1,8'h22};
      vecs[6]  = '{1'b0,1'b0,1'b1,8'h00, 3'd2,3'd4,6'b000010,1'b1,8'h33};
      vecs[7]  = '{1'b0,1'b0,1'b1,8'h00, 3'd1,3'd4,6'b001010,1'b1,8'h44};
      vecs[8]  = '{1'b0,1'b0,1'b1,8'h00, 3'd0,3'd4,6'b101010,1'b0,8'h00};
      vecs[9]  = '{1'b0,1'b0,1'b1,8'h00, 3'd0,3'd4,6'b101011,1'b0,8'h00};
      vecs[10] = '{1'b1,1'b0,1'b0,8'h00, 3'd0,3'd0,6'b101000,1'b0,8'h00};
      vecs[11] = '{1'b0,1'b1,1'b0,8'h11, 3'd1,3'd1,6'b001000,1'b1,8'h11};
      vecs[12] = '{1'b0,1'b1,1'b0,8'h22, 3'd2,3'd2,6'b000000,1'b1,8'h11};
      vecs[13] = '{1'b0,1'b1,1'b0,8'h33, 3'd3,3'd3,6'b000100,1'b1,8'h11};
      vecs[14] = '{1'b0,1'b1,1'b0,8'h44, 3'd4,3'd4,6'b010100,1'b1,8'h11};
      vecs[15] = '{1'b0,1'b1,1'b1,8'h66, 3'd4,3'd4,6'b010100,1'b1,8'h22};
      vecs[16] = '{1'b0,1'b0,1'b1,8'h00, 3'd3,3'd4,6'b000100,1'b1,8'h33};
      vecs[17] = '{1'b0,1'b0,1'b1,8'h00, 3'd2,3'd4,6'b000000,1'b1,8'h44};
      vecs[18] = '{1'b0,1'b0,1'b1,8'h00, 3'd1,3'd4,6'b001000,1'b1,8'h66};
      vecs[19] = '{1'b0,1'b0,1'b1,8'h00, 3'd0,3'd4,6'b101000,1'b0,8'h00};
      vecs[20] = '{1'b0,1'b1,1'b1,8'h77, 3'd1,3'd4,6'b001001,1'b1,8'h77};
      vecs[21] = '{1'b0,1'b0,1'b1,8'h00, 3'd0,3'd4,6'b101001,1'b0,8'h00};
      vecs[22] = '{1'b1,1'b1,1'b0,8'h99, 3'd0,3'd0,6'b101000,1'b0,8'h00};
      vecs[23] = '{1'b0,1'b0,1'b0,8'h00, 3'd0,3'd0,6'b101000,1'b0,8'h00};

      reset_n = 1'b0; flush = 1'b0; wr = 1'b0; rd = 1'b0; w_data = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_count", int'(count), 0);
      chk("reset_hwm", int'(hwm), 0);
      chk("reset_flags", int'(flags_now()), int'(6'b101000));
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 24; i++) begin
         step(vecs[i].fl, vecs[i].w, vecs[i].r, vecs[i].wd);
         chk($sformatf("vec%0d_count", i), int'(count), int'(vecs[i].cnt));
         chk($sformatf("vec%0d_hwm", i), int'(hwm), int'(vecs[i].hw));
         chk($sformatf("vec%0d_flags", i), int'(flags_now()), int'(vecs[i].flg));
         if (vecs[i].chk)
            chk($sformatf("vec%0d_rdata", i), int'(r_data), int'(vecs[i].rdv));
      end

      // Randomized run; the table leaves the FIFO empty with all status cleared.
      mq.delete(); m_hwm = 0; m_ovf = 0; m_udf = 0;
      for (int i = 0; i < 600; i++) begin
         f = ($urandom_range(0, 63) == 0);
         if ((i / 40) % 2 == 0) begin
            w = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 3) == 0);
         end else begin
            w = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 3) != 0);
         end
         d = 8'($urandom);
         model_step(f, w, r, d);
         step(f, w, r, d);
         n = mq.size();
         exp_flg = {n == 0, n == 4, n <= 1, n >= 3, m_ovf, m_udf};
         chk("rand_count", int'(count), n);
         chk("rand_hwm", int'(hwm), m_hwm);
         chk("rand_flags", int'(flags_now()), int'(exp_flg));
         if (n != 0) chk("rand_rdata", int'(r_data), int'(mq[0]));
      end

      // Async reset asserted between edges while a write is pending.
      step(1'b0, 1'b1, 1'b0, 8'hC1);
      step(1'b0, 1'b1, 1'b0, 8'hC2);
      step(1'b0, 1'b1, 1'b1, 8'hC3);
      wr = 1'b1; rd = 1'b1; w_data = 8'hC4;
      #3;
      reset_n = 1'b0;
      #1;
      chk("areset_count", int'(count), 0);
      chk("areset_hwm", int'(hwm), 0);
      chk("areset_flags", int'(flags_now()), int'(6'b101000));
      wr = 1'b0; rd = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      step(1'b0, 1'b1, 1'b0, 8'hA5);
      step(1'b0, 1'b1, 1'b0, 8'h5A);
      chk("post_reset_count", int'(count), 2);
      chk("post_reset_rdata", int'(r_data), 8'hA5);
      chk("post_reset_flags", int'(flags_now()), int'(6'b000000));
      step(1'b0, 1'b0, 1'b1, 8'h00);
      chk("post_reset_pop", int'(r_data), 8'h5A);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
